sram_model: RTL and testbench
=============================

SRAM_MODEL -- requirements
Module: sram_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W (131072), number of implemented words.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port SRAM_WE_N  input  1  active-low write enable; 1 = read cycle.
REQ-007 SHALL have port SRAM_ADDR  input  ADDR_W  word address.
REQ-008 SHALL have port SRAM_DQ  inout  DATA_W  bidirectional data bus, shared with the processor.

Function
REQ-009 SHALL store DEPTH words of DATA_W bits plus one valid bit per word.
REQ-010 Write: on rising clk with reset high, SRAM_WE_N=0 and SRAM_ADDR<DEPTH, SHALL store SRAM_DQ at SRAM_ADDR and set its valid bit.
REQ-011 Out-of-range write (SRAM_ADDR>=DEPTH) SHALL be ignored, with no state change.
REQ-012 Read: while reset high and SRAM_WE_N=1, SHALL drive SRAM_DQ combinationally with the word at SRAM_ADDR (zero-latency, asynchronous read).
REQ-013 A read of an invalid (never-written-since-reset) word or an out-of-range address SHALL return all zeros.
REQ-014 While SRAM_WE_N=0, SHALL release SRAM_DQ to high-Z; the processor drives the bus.
REQ-015 While reset is low, SHALL release SRAM_DQ to high-Z.
REQ-016 Read-after-write: data written at edge N SHALL be visible on SRAM_DQ as soon as SRAM_WE_N returns to 1 after edge N.
REQ-017 Back-to-back writes to the same address: the last write SHALL win.
REQ-018 Consecutive writes on every edge SHALL each complete; there is no busy/handshake state.
REQ-019 SRAM_DQ bits that are X/Z during a write SHALL be stored as-is, with no masking.
REQ-020 Address changes during a read SHALL propagate to SRAM_DQ with no clock involvement.

Reset
REQ-021 Assertion of reset (low), asynchronously and independent of clk, SHALL clear every valid bit, so all words read as zero.
REQ-022 SHALL not require clearing data words on reset; only the valid bits are cleared.
REQ-023 A write presented on the same edge where reset is low SHALL be discarded.
REQ-024 After reset deasserts, the first rising clk SHALL accept a write normally.

Structure
REQ-025 Shared package sram_pkg SHALL hold default ADDR_W, DATA_W and an addr_t/data_t typedef; the processor side uses the same package.
REQ-026 SHALL implement the storage/valid array in one sub-module, sram_array (write port plus asynchronous read port); the top handles tri-state, range check and the reset gating.
REQ-027 The tri-state driver SHALL be a single continuous assignment, with no internal bus contention.

Verification
REQ-028 Reset low 200 ns then high; read addresses 0, 1 and 0x1FFFF -> SRAM_DQ = 0x00000000 for each.
REQ-029 Write 0xDEADBEEF @0x00010, then set WE_N=1 at the same address -> SRAM_DQ = 0xDEADBEEF immediately.
REQ-030 Write 0x11111111 then 0x22222222 to @0x00005 on consecutive edges -> read returns 0x22222222; @0x00006 still reads 0.
REQ-031 While WE_N=0 -> model output is Z; bench-driven value is seen unchanged on the bus; with reset low -> bus is Z regardless of WE_N.
REQ-032 Fill addresses 0..15 with 0x100+i, pulse reset low mid-run (not clock-aligned) -> all sixteen read 0; rewrite @3 = 0xA5A5A5A5 -> reads 0xA5A5A5A5, and @4 reads 0.
REQ-033 With DEPTH=1024, write 0xCAFEF00D @1024 -> ignored; read @1024 = 0 and @0 unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM definitions used by both the memory model and the processor side.
package sram_pkg;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/sram_model_if.sv
// Control/address side of the SRAM bus; the data bus is a plain inout on the model.
interface sram_model_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              SRAM_WE_N;
    logic [ADDR_W-1:0] SRAM_ADDR;

    modport master (output SRAM_WE_N, SRAM_ADDR);
    modport slave  (input  SRAM_WE_N, SRAM_ADDR);
endinterface

// File: rtl/sram_array.sv
// Word storage with one synchronous write port, one asynchronous read port and
// a per-word valid bit that is cleared asynchronously on reset.
module sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Data words carry no reset; the valid bits alone define what reads back.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  valid        <= '0;
        else if (we) valid[waddr] <= 1'b1;
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];
endmodule

// File: rtl/sram_model.sv
// Behavioural asynchronous SRAM: range check, reset gating and the single
// tri-state driver around an sram_array.
module sram_model
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    sram_model_if.slave       bus,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              in_range;
    logic              we;
    logic              dq_oe;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_rvalid;
    logic [DATA_W-1:0] rd_data;

    assign in_range = ({1'b0, bus.SRAM_ADDR} < DEPTH_L);
    // Including reset here discards a write presented while reset is held low.
    assign we       = reset & ~bus.SRAM_WE_N & in_range;
    assign dq_oe    = reset & bus.SRAM_WE_N;
    assign rd_data  = (in_range && arr_rvalid) ? arr_rdata : '0;

    assign SRAM_DQ  = dq_oe ? rd_data : 'z;

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst_n  (reset),
        .we     (we),
        .waddr  (bus.SRAM_ADDR[IDX_W-1:0]),
        .wdata  (SRAM_DQ),
        .raddr  (bus.SRAM_ADDR[IDX_W-1:0]),
        .rdata  (arr_rdata),
        .rvalid (arr_rvalid)
    );
endmodule

// File: tb/tb_sram_model.sv
// Directed bench for sram_model: vector table plus hand sequences for the
// bus-release, reset and out-of-range corners.
module tb_sram_model;
    import sram_pkg::*;

    logic  clk;
    logic  reset;
    logic  tb_oe, tb_oe2;
    data_t tb_val, tb_val2;
    wire  [31:0] dq;
    wire  [31:0] dq2;

    int checks   = 0;
    int failures = 0;

    sram_model_if #(.ADDR_W(17)) bi ();
    sram_model_if #(.ADDR_W(17)) bi2 ();

    assign dq  = tb_oe  ? tb_val  : 'z;
    assign dq2 = tb_oe2 ? tb_val2 : 'z;

    sram_model #(.ADDR_W(17), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bi),
        .SRAM_DQ (dq)
    );

    sram_model #(.ADDR_W(17), .DATA_W(32), .DEPTH(1024)) dut_s (
        .clk     (clk),
        .reset   (reset),
        .bus     (bi2),
        .SRAM_DQ (dq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic  we_n;
        addr_t addr;
        data_t data;
        data_t exp;
        string nm;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic wr(input addr_t a, input data_t d);
        @(negedge clk);
        bi.SRAM_WE_N = 1'b0;
        bi.SRAM_ADDR = a;
        tb_val       = d;
        tb_oe        = 1'b1;
    endtask

    task automatic rd(input addr_t a, input data_t exp, input string nm);
        @(negedge clk);
        tb_oe        = 1'b0;
        bi.SRAM_WE_N = 1'b1;
        bi.SRAM_ADDR = a;
        #1;
        chk(nm, dq, exp);
    endtask

    task automatic wr2(input addr_t a, input data_t d);
        @(negedge clk);
        bi2.SRAM_WE_N = 1'b0;
        bi2.SRAM_ADDR = a;
        tb_val2       = d;
        tb_oe2        = 1'b1;
    endtask

    task automatic rd2(input addr_t a, input data_t exp, input string nm);
        @(negedge clk);
        tb_oe2        = 1'b0;
        bi2.SRAM_WE_N = 1'b1;
        bi2.SRAM_ADDR = a;
        #1;
        chk(nm, dq2, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 17'h00000, 32'h0,        32'h00000000, "rst_rd_0"};
        tbl[1]  = '{1'b1, 17'h00001, 32'h0,        32'h00000000, "rst_rd_1"};
        tbl[2]  = '{1'b1, 17'h1FFFF, 32'h0,        32'h00000000, "rst_rd_top"};
        tbl[3]  = '{1'b0, 17'h00005, 32'h11111111, 32'h0,        "wr5_a"};
        tbl[4]  = '{1'b0, 17'h00005, 32'h22222222, 32'h0,        "wr5_b"};
        tbl[5]  = '{1'b1, 17'h00005, 32'h0,        32'h22222222, "last_wins"};
        tbl[6]  = '{1'b1, 17'h00006, 32'h0,        32'h00000000, "neighbour_6"};
        tbl[7]  = '{1'b0, 17'h1FFFF, 32'h13579BDF, 32'h0,        "wr_top"};
        tbl[8]  = '{1'b1, 17'h1FFFF, 32'h0,        32'h13579BDF, "rd_top"};
        tbl[9]  = '{1'b1, 17'h00000, 32'h0,        32'h00000000, "rd_0_still"};
        tbl[10] = '{1'b0, 17'h00000, 32'hFFFFFFFF, 32'h0,        "wr_0_ones"};
        tbl[11] = '{1'b1, 17'h00000, 32'h0,        32'hFFFFFFFF, "rd_0_ones"};
        tbl[12] = '{1'b1, 17'h1FFFF, 32'h0,        32'h13579BDF, "rd_top_again"};

        reset         = 1'b0;
        tb_oe         = 1'b0;
        tb_oe2        = 1'b0;
        tb_val        = '0;
        tb_val2       = '0;
        bi.SRAM_WE_N  = 1'b1;
        bi.SRAM_ADDR  = '0;
        bi2.SRAM_WE_N = 1'b1;
        bi2.SRAM_ADDR = '0;
        #200;
        reset = 1'b1;

        // Table: writes land on the posedge following their negedge setup.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bi.SRAM_WE_N = tbl[i].we_n;
            bi.SRAM_ADDR = tbl[i].addr;
            tb_val       = tbl[i].data;
            tb_oe        = ~tbl[i].we_n;
            #1;
            if (tbl[i].we_n) chk(tbl[i].nm, dq, tbl[i].exp);
        end

        // Read-after-write with zero latency once WE_N returns high.
        wr(17'h00010, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        bi.SRAM_WE_N = 1'b1;
        tb_oe        = 1'b0;
        #1;
        chk("raw_deadbeef", dq, 32'hDEADBEEF);
        bi.SRAM_ADDR = 17'h00005;
        #1;
        chk("addr_async", dq, 32'h22222222);

        // Bus released while writing: bench pattern and its inverse pass untouched.
        @(negedge clk);
        bi.SRAM_WE_N = 1'b0;
        bi.SRAM_ADDR = 17'h00010;
        tb_val       = 32'hA5A50F0F;
        tb_oe        = 1'b1;
        #1;
        chk("we_bus_pat", dq, 32'hA5A50F0F);
        tb_val = 32'h5A5AF0F0;
        #1;
        chk("we_bus_inv", dq, 32'h5A5AF0F0);
        chk("we_oe_off", {31'b0, dut.dq_oe}, 32'h0);
        bi.SRAM_WE_N = 1'b1;
        tb_oe        = 1'b0;

        // Reset low: bus released regardless of WE_N, and writes are discarded.
        @(negedge clk);
        #2;
        reset        = 1'b0;
        tb_val       = 32'h3C3C3C3C;
        tb_oe        = 1'b1;
        #1;
        chk("rst_bus_pat", dq, 32'h3C3C3C3C);
        chk("rst_oe_rd", {31'b0, dut.dq_oe}, 32'h0);
        bi.SRAM_WE_N = 1'b0;
        bi.SRAM_ADDR = 17'h00020;
        tb_val       = 32'h77777777;
        #1;
        chk("rst_oe_wr", {31'b0, dut.dq_oe}, 32'h0);
        @(posedge clk);
        #1;
        bi.SRAM_WE_N = 1'b1;
        tb_oe        = 1'b0;
        reset        = 1'b1;
        rd(17'h00020, 32'h0, "rst_wr_dropped");
        rd(17'h00010, 32'h0, "rst_cleared_10");

        // Fill 0..15, async reset pulse, then write on the first edge after release.
        for (int i = 0; i < 16; i++) wr(addr_t'(i), 32'h100 + i);
        rd(17'h0000F, 32'h10F, "fill_15");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        reset        = 1'b1;
        bi.SRAM_WE_N = 1'b0;
        bi.SRAM_ADDR = 17'h00003;
        tb_val       = 32'hA5A5A5A5;
        tb_oe        = 1'b1;
        for (int i = 0; i < 16; i++)
            rd(addr_t'(i), (i == 3) ? 32'hA5A5A5A5 : 32'h0, $sformatf("pulse_rd_%0d", i));

        // Reduced-depth instance: address 1024 is out of range.
        wr2(17'h00000, 32'h0BADC0DE);
        wr2(17'h003FF, 32'h12345678);
        wr2(17'h00400, 32'hCAFEF00D);
        rd2(17'h00400, 32'h0,        "oor_1024");
        rd2(17'h00000, 32'h0BADC0DE, "oor_0_kept");
        rd2(17'h003FF, 32'h12345678, "depth_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
